tmds_link_encoder: RTL and testbench

Parametrised single-clock TMDS link encoder: encodes CHANNELS channels of 8-bit video/2-bit control into 10-bit TMDS symbols at pixel rate. Runs in DVI mode (plain video/control coding) or HDMI mode, where it inserts the 8-cycle video preamble and 2-cycle video guard band ahead of every active line. It sits between the display timing/pixel pipeline and the 10:1 serializers. Fixed latency in both modes.

---
 rtl/tmds_link_encoder.sv | 186 ++++++++++++++++++
 tb/tb_tmds_link_encoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_link_encoder.sv
// TMDS link encoder: fixed-latency 8b/10b video/control coding with HDMI video preamble and guard insertion.
// Defining TMDS_LINK_STATUS_EN adds the sticky o_blank_short status output.
module tmds_link_encoder #(
    parameter int CHANNELS = 3,
    parameter int PRE_LEN  = 8,
    parameter int GB_LEN   = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_hdmi_en,
    input  logic                   i_de,
    input  logic [8*CHANNELS-1:0]  i_data,
    input  logic [2*CHANNELS-1:0]  i_ctrl,
    output logic [10*CHANNELS-1:0] o_tmds,
    output logic                   o_de
`ifdef TMDS_LINK_STATUS_EN
    ,
    output logic                   o_blank_short
`endif
);
    localparam int D = PRE_LEN + GB_LEN;
    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] GB_VID  = 10'b1011001100;
    localparam logic [9:0] GB_CH1  = 10'b0100110011;

    typedef enum logic [1:0] {IDLE, PREAMBLE, GUARD, ACTIVE} state_t;
    typedef struct packed {
        logic signed [4:0] disp;
        logic [9:0]        sym;
    } enc_t;

    function automatic logic [9:0] encode_ctrl(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'b1101010100;
            2'b01:   s = 10'b0010101011;
            2'b10:   s = 10'b0101010100;
            default: s = 10'b1010101011;
        endcase
        return s;
    endfunction

    function automatic enc_t encode_video(input logic [7:0] d, input logic signed [4:0] disp);
        logic [8:0]        qm;
        logic [3:0]        n1d;
        logic [3:0]        n1q;
        logic signed [5:0] diff;
        logic signed [5:0] acc;
        enc_t              r;
        n1d = '0;
        n1q = '0;
        for (int i = 0; i < 8; i++) n1d = n1d + {3'b000, d[i]};
        qm[0] = d[0];
        if (n1d > 4'd4 || (n1d == 4'd4 && !d[0])) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        for (int i = 0; i < 8; i++) n1q = n1q + {3'b000, qm[i]};
        // diff = ones - zeros of the minimised byte
        diff = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
        acc  = {disp[4], disp};
        if (disp == 5'sd0 || diff == 6'sd0) begin
            r.sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            acc   = qm[8] ? acc + diff : acc - diff;
        end else if ((!disp[4] && diff > 6'sd0) || (disp[4] && diff < 6'sd0)) begin
            r.sym = {1'b1, qm[8], ~qm[7:0]};
            acc   = acc + (qm[8] ? 6'sd2 : 6'sd0) - diff;
        end else begin
            r.sym = {1'b0, qm[8], qm[7:0]};
            acc   = acc - (qm[8] ? 6'sd0 : 6'sd2) + diff;
        end
        r.disp = acc[4:0];
        return r;
    endfunction

    logic [D-1:0]           de_dl;
    logic [8*CHANNELS-1:0]  data_dl [D];
    logic [2*CHANNELS-1:0]  ctrl_dl [D];
    logic                   de_prev;
    logic                   rise;
    logic                   dd;
    state_t                 state, cur_state, nxt_state;
    logic [3:0]             cnt, cur_cnt, nxt_cnt;
    logic signed [4:0]      disp [CHANNELS];
    enc_t                   vid [CHANNELS];
    logic [10*CHANNELS-1:0] tmds_nxt;

    assign rise = i_de & ~de_prev;
    assign dd   = de_dl[D-1];

    // Delay line: D stages of lookahead between the edge detector and the encoder
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            de_dl   <= '0;
            de_prev <= 1'b0;
            for (int i = 0; i < D; i++) begin
                data_dl[i] <= '0;
                ctrl_dl[i] <= '0;
            end
        end else begin
            de_dl      <= {de_dl[D-2:0], i_de};
            de_prev    <= i_de;
            data_dl[0] <= i_data;
            ctrl_dl[0] <= i_ctrl;
            for (int i = 1; i < D; i++) begin
                data_dl[i] <= data_dl[i-1];
                ctrl_dl[i] <= ctrl_dl[i-1];
            end
        end
    end

    // Override FSM: an undelayed rise lines up the window with the delay-line output this cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
        end
    end

    always_comb begin
        cur_state = state;
        cur_cnt   = cnt;
        if (rise) begin
            cur_state = i_hdmi_en ? PREAMBLE : (dd ? ACTIVE : IDLE);
            cur_cnt   = '0;
        end
        nxt_state = cur_state;
        nxt_cnt   = '0;
        case (cur_state)
            PREAMBLE: if (cur_cnt == 4'(PRE_LEN - 1)) nxt_state = GUARD;
                      else nxt_cnt = cur_cnt + 4'd1;
            GUARD:    if (cur_cnt == 4'(GB_LEN - 1)) nxt_state = ACTIVE;
                      else nxt_cnt = cur_cnt + 4'd1;
            ACTIVE:   if (!dd) nxt_state = IDLE;
            default:  if (dd) nxt_state = ACTIVE;
        endcase
    end

    // Encoder stage: delayed video always wins over a pending preamble/guard
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++)
            vid[ch] = encode_video(data_dl[D-1][8*ch +: 8], disp[ch]);
    end

    always_comb begin
        tmds_nxt = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (dd)
                tmds_nxt[10*ch +: 10] = vid[ch].sym;
            else if (cur_state == GUARD)
                tmds_nxt[10*ch +: 10] = (ch == 1) ? GB_CH1 : GB_VID;
            else if (cur_state == PREAMBLE && ch != 0)
                tmds_nxt[10*ch +: 10] = encode_ctrl((ch == 1) ? 2'b01 : 2'b00);
            else
                tmds_nxt[10*ch +: 10] = encode_ctrl(ctrl_dl[D-1][2*ch +: 2]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_tmds <= {CHANNELS{CTRL_00}};
            o_de   <= 1'b0;
            for (int ch = 0; ch < CHANNELS; ch++) disp[ch] <= 5'sd0;
        end else begin
            o_tmds <= tmds_nxt;
            o_de   <= dd;
            for (int ch = 0; ch < CHANNELS; ch++) disp[ch] <= dd ? vid[ch].disp : 5'sd0;
        end
    end

`ifdef TMDS_LINK_STATUS_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            o_blank_short <= 1'b0;
        else if (dd && (cur_state == PREAMBLE || cur_state == GUARD))
            o_blank_short <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_tmds_link_encoder.sv
// Scoreboard bench for tmds_link_encoder: a time-since-rise reference model predicts every output symbol.
module tb_tmds_link_encoder;
    localparam int CH  = 3;
    localparam int PRE = 8;
    localparam int GB  = 2;
    localparam int D   = PRE + GB;
    localparam int DW  = 8 * CH;
    localparam int CW  = 2 * CH;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           hdmi_en;
    logic           de;
    logic [DW-1:0]  data;
    logic [CW-1:0]  ctrl;
    logic [10*CH-1:0] tmds;
    logic           de_out;
`ifdef TMDS_LINK_STATUS_EN
    logic           blank_short;
`endif

    always #5 clk = ~clk;

    tmds_link_encoder #(.CHANNELS(CH), .PRE_LEN(PRE), .GB_LEN(GB)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_hdmi_en (hdmi_en),
        .i_de      (de),
        .i_data    (data),
        .i_ctrl    (ctrl),
        .o_tmds    (tmds),
        .o_de      (de_out)
`ifdef TMDS_LINK_STATUS_EN
        ,
        .o_blank_short (blank_short)
`endif
    );

    typedef struct packed {
        logic [10*CH-1:0] tmds;
        logic             de;
        logic             blank;
    } exp_t;

    typedef struct packed {
        logic          de;
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } in_t;

    bit [9:0] CTRL_TAB [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    exp_t exp_q [$];
    in_t  pipe [$];
    int   since_rise;
    bit   line_hdmi;
    bit   prev_de;
    int   disp_m [CH];
    bit   blank_m;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void ref_video(input bit [7:0] d, input int cin, output int cout, output bit [9:0] q);
        bit [8:0] qm;
        bit       xn;
        int       ones;
        int       zeros;
        xn = ($countones(d) > 4) || ($countones(d) == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~xn;
        ones  = $countones(qm[7:0]);
        zeros = 8 - ones;
        cout  = cin;
        if (cin == 0 || ones == zeros) begin
            q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cout += qm[8] ? (ones - zeros) : (zeros - ones);
        end else if ((cin > 0 && ones > zeros) || (cin < 0 && zeros > ones)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            cout += (qm[8] ? 2 : 0) + zeros - ones;
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            cout += ones - zeros - (qm[8] ? 0 : 2);
        end
    endfunction

    function automatic void model_reset();
        in_t z;
        z = '0;
        pipe.delete();
        for (int i = 0; i < D; i++) pipe.push_back(z);
        since_rise = 1 << 20;
        line_hdmi  = 1'b0;
        prev_de    = 1'b0;
        blank_m    = 1'b0;
        for (int ch = 0; ch < CH; ch++) disp_m[ch] = 0;
    endfunction

    // One input cycle: drive on the falling edge, predict the output of the following rising edge.
    task automatic drive(input bit rn, input bit d_e, input bit h, input logic [DW-1:0] dat, input logic [CW-1:0] c);
        exp_t     e;
        in_t      cur;
        in_t      old;
        bit       dd;
        bit [9:0] sym;
        int       nd;
        @(negedge clk);
        rst_n   = rn;
        de      = d_e;
        hdmi_en = h;
        data    = dat;
        ctrl    = c;
        e = '0;
        if (!rn) begin
            model_reset();
            e.tmds = {CH{10'h354}};
        end else begin
            old = pipe.pop_front();
            dd  = old.de;
            if (d_e && !prev_de) begin
                since_rise = 0;
                line_hdmi  = h;
            end else if (since_rise < 1000) begin
                since_rise++;
            end
            for (int ch = 0; ch < CH; ch++) begin
                if (dd) begin
                    ref_video(old.data[8*ch +: 8], disp_m[ch], nd, sym);
                    disp_m[ch] = nd;
                end else begin
                    disp_m[ch] = 0;
                    if (line_hdmi && since_rise < PRE)
                        sym = (ch == 0) ? CTRL_TAB[old.ctrl[1:0]] : (ch == 1 ? CTRL_TAB[1] : CTRL_TAB[0]);
                    else if (line_hdmi && since_rise < D)
                        sym = (ch == 1) ? 10'b0100110011 : 10'b1011001100;
                    else
                        sym = CTRL_TAB[old.ctrl[2*ch +: 2]];
                end
                e.tmds[10*ch +: 10] = sym;
            end
            if (dd && line_hdmi && since_rise < D) blank_m = 1'b1;
            e.de    = dd;
            e.blank = blank_m;
            cur.de   = d_e;
            cur.data = dat;
            cur.ctrl = c;
            pipe.push_back(cur);
            prev_de = d_e;
        end
        exp_q.push_back(e);
    endtask

    task automatic line(input bit h, input int nblank, input int nact, input int fixdata, input int ctrl0, input bit toggle);
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        for (int i = 0; i < nblank; i++) begin
            c = CW'($urandom);
            if (ctrl0 >= 0) c[1:0] = 2'(ctrl0);
            drive(1'b1, 1'b0, h, DW'($urandom), c);
        end
        for (int i = 0; i < nact; i++) begin
            d = (fixdata >= 0) ? {CH{8'(fixdata)}} : DW'($urandom);
            drive(1'b1, 1'b1, (toggle && i >= nact / 2) ? !h : h, d, CW'($urandom));
        end
    endtask

    // Monitor: one output symbol per rising edge, checked 2 ns after the edge
    initial begin
        exp_t e;
        int   edge_no;
        edge_no = 0;
        forever begin
            @(posedge clk);
            #2;
            edge_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (tmds !== e.tmds) begin
                    n_bad++;
                    $display("FAIL tmds edge %0d: got %h required %h", edge_no, tmds, e.tmds);
                end
                n_cmp++;
                if (de_out !== e.de) begin
                    n_bad++;
                    $display("FAIL o_de edge %0d: got %b required %b", edge_no, de_out, e.de);
                end
`ifdef TMDS_LINK_STATUS_EN
                n_cmp++;
                if (blank_short !== e.blank) begin
                    n_bad++;
                    $display("FAIL blank_short edge %0d: got %b required %b", edge_no, blank_short, e.blank);
                end
`endif
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        de      = 1'b0;
        hdmi_en = 1'b0;
        data    = '0;
        ctrl    = '0;
        model_reset();
        repeat (3) drive(1'b0, 1'($urandom), 1'($urandom), DW'($urandom), CW'($urandom));
        repeat (20) drive(1'b1, 1'b0, 1'b0, '0, '0);
        line(1'b0, 20, 16, 0, -1, 1'b0);
        line(1'b1, 20, 16, -1, 3, 1'b0);
        for (int n = 0; n < 8; n++)
            line(1'($urandom), D + int'($urandom_range(0, 10)), int'($urandom_range(1, 24)), -1, -1, 1'b0);
        line(1'b1, 15, 12, -1, -1, 1'b0);
        line(1'b1, 4, 12, -1, -1, 1'b0);
        line(1'b1, 4, 12, -1, -1, 1'b0);
        for (int n = 0; n < 4; n++)
            line(1'b1, int'($urandom_range(1, D - 1)), int'($urandom_range(1, 14)), -1, -1, 1'b0);
        line(1'b1, 15, 16, -1, -1, 1'b1);
        line(1'b0, 15, 10, -1, -1, 1'b0);
        line(1'b0, 15, 16, -1, -1, 1'b1);
        line(1'b1, 15, 10, -1, -1, 1'b0);
        line(1'b1, 15, 3, -1, -1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, DW'($urandom), CW'($urandom));
        line(1'b1, 20, 8, -1, -1, 1'b0);
        repeat (20) drive(1'b1, 1'b0, 1'b0, DW'($urandom), CW'($urandom));
        repeat (2) @(posedge clk);
        #4;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected symbols left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
